// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared encodings for the multicycle control unit.
// Holds opcode values, FSM state encoding, branch condition codes and
// ALU function codes, plus small decode helpers used by the controller.
package multicycle_ctrl_pkg;

    localparam int OPC_W = 5;

    // Major opcodes carried in IR[15:11]
    localparam logic [OPC_W-1:0] OP_ALU = 5'b00000;
    localparam logic [OPC_W-1:0] OP_CMP = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LHI = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LLI = 5'b00011;
    localparam logic [OPC_W-1:0] OP_LDR = 5'b00100;
    localparam logic [OPC_W-1:0] OP_STR = 5'b00101;
    localparam logic [OPC_W-1:0] OP_BCC = 5'b00110;
    localparam logic [OPC_W-1:0] OP_NOP = 5'b00111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXE    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Branch conditions carried in IR[10:8]
    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_CS = 3'b011;
    localparam logic [2:0] COND_CC = 3'b100;
    localparam logic [2:0] COND_MI = 3'b101;
    localparam logic [2:0] COND_PL = 3'b110;
    localparam logic [2:0] COND_NV = 3'b111;

    // ALU function field carried in IR[1:0] of the ALU opcode
    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_ADC = 2'b01;
    localparam logic [1:0] FN_SUB = 2'b10;
    localparam logic [1:0] FN_SBC = 2'b11;

    // Subtracting functions drive ALUop high
    function automatic logic fn_is_sub(input logic [1:0] fn);
        return (fn == FN_SUB) || (fn == FN_SBC);
    endfunction

    // Carry-chained functions feed PSW carry into the ALU
    function automatic logic fn_uses_carry(input logic [1:0] fn);
        return (fn == FN_ADC) || (fn == FN_SBC);
    endfunction

    // Only the lower eight opcodes are defined
    function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
        return op[4:3] == 2'b00;
    endfunction

    // STR needs Rd as store data, LHI needs Rd to merge its low byte
    function automatic logic op_reads_rd(input logic [OPC_W-1:0] op);
        return (op == OP_STR) || (op == OP_LHI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_eval.sv
// mc_cond_eval: combinational branch-condition evaluator.
// Maps a 3-bit condition code and the N/Z/C flags to a taken indication.
module mc_cond_eval
    import multicycle_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_c,
    output logic       taken
);

    // Select the flag test named by the condition code
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = flag_z;
            COND_NE: taken = ~flag_z;
            COND_CS: taken = flag_c;
            COND_CC: taken = ~flag_c;
            COND_MI: taken = flag_n;
            COND_PL: taken = ~flag_n;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXE/MEM/WB control unit for the RF+ALU datapath.
// Owns the instruction register, the PSW {N,Z,C} and the memory handshake.
// Outputs are Moore-decoded from the registered state and IR; only pc_write
// during fetch follows mem_ready directly. Every output reads 0 while Reset
// is high so an interrupted access is dropped immediately.
// Build option: define MULTICYCLE_CTRL_TRAP_EN to trap opcodes 01000-11111
// into a sticky halt state; without it they behave as NOP and halt is 0.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int INS_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [INS_W-1:0] mem_rdata,
    input  logic             mem_ready,
    input  logic             N,
    input  logic             Z,
    input  logic             C,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_isfetch,
    output logic             pc_write,
    output logic             pc_branch,
    output logic [10:0]      Ins,
    output logic             WBRF,
    output logic             WBresource,
    output logic             RBresource,
    output logic             OprandB,
    output logic             LI,
    output logic             ALUop,
    output logic             Flag,
    output logic             PSW_C,
    output logic             mem_err,
    output logic             halt
);

    localparam int WCW = $clog2(WAIT_MAX + 1);
    // Last wait count that is still tolerated; one more miss raises mem_err
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

    state_t           state;
    logic [INS_W-1:0] ir;
    logic [2:0]       psw;
    logic [WCW-1:0]   wait_cnt;
    logic             mem_err_q;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic             halt_q;
`endif

    logic [OPC_W-1:0] opcode;
    logic [1:0]       alu_fn;
    logic             cond_taken;

    assign opcode = ir[INS_W-1 -: OPC_W];
    assign alu_fn = ir[1:0];

    // Branch condition is judged against the committed PSW, not live ALU flags
    mc_cond_eval u_cond_eval (
        .cond   (ir[10:8]),
        .flag_n (psw[2]),
        .flag_z (psw[1]),
        .flag_c (psw[0]),
        .taken  (cond_taken)
    );

    // State sequencing, IR capture, PSW update and memory wait supervision
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            ir        <= '0;
            psw       <= 3'b000;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            halt_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end

                S_FETCH: begin
                    if (mem_ready) begin
                        ir       <= mem_rdata;
                        wait_cnt <= '0;
                        state    <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_err_q <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end

                S_DECODE: begin
                    if (!op_is_legal(opcode)) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                        halt_q <= 1'b1;
                        state  <= S_HALT;
`else
                        state  <= S_FETCH;
`endif
                    end else if (opcode == OP_NOP) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_EXE;
                    end
                end

                S_EXE: begin
                    if ((opcode == OP_ALU) || (opcode == OP_CMP)) begin
                        psw <= {N, Z, C};
                    end
                    case (opcode)
                        OP_LDR, OP_STR: state <= S_MEM;
                        OP_CMP, OP_BCC: state <= S_FETCH;
                        default:        state <= S_WB;
                    endcase
                end

                S_MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        state    <= (opcode == OP_LDR) ? S_WB : S_FETCH;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_err_q <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end

                S_WB: begin
                    state <= S_FETCH;
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore control decode from state and IR, forced quiet while Reset is high
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_isfetch = 1'b0;
        pc_write    = 1'b0;
        pc_branch   = 1'b0;
        Ins         = ir[10:0];
        WBRF        = 1'b0;
        WBresource  = 1'b0;
        RBresource  = 1'b0;
        OprandB     = 1'b0;
        LI          = 1'b0;
        ALUop       = 1'b0;
        Flag        = 1'b0;
        PSW_C       = psw[0];
        mem_err     = mem_err_q;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        halt        = halt_q;
`else
        halt        = 1'b0;
`endif

        case (state)
            S_FETCH: begin
                mem_req     = 1'b1;
                mem_isfetch = 1'b1;
                pc_write    = mem_ready;
            end

            S_DECODE: begin
                RBresource = op_reads_rd(opcode);
            end

            S_EXE: begin
                RBresource = op_reads_rd(opcode);
                case (opcode)
                    OP_ALU: begin
                        ALUop = fn_is_sub(alu_fn);
                        Flag  = fn_uses_carry(alu_fn);
                    end
                    OP_CMP: begin
                        ALUop = 1'b1;
                    end
                    OP_LDR, OP_STR: begin
                        OprandB = 1'b1;
                    end
                    OP_BCC: begin
                        pc_write  = cond_taken;
                        pc_branch = cond_taken;
                    end
                    default: begin
                    end
                endcase
            end

            S_MEM: begin
                mem_req    = 1'b1;
                mem_we     = (opcode == OP_STR);
                RBresource = op_reads_rd(opcode);
            end

            S_WB: begin
                WBRF       = 1'b1;
                WBresource = (opcode == OP_LDR);
                LI         = (opcode == OP_LHI);
                RBresource = op_reads_rd(opcode);
            end

            S_HALT: begin
                Ins = '0;
            end

            default: begin
            end
        endcase

        if (Reset) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            mem_isfetch = 1'b0;
            pc_write    = 1'b0;
            pc_branch   = 1'b0;
            Ins         = '0;
            WBRF        = 1'b0;
            WBresource  = 1'b0;
            RBresource  = 1'b0;
            OprandB     = 1'b0;
            LI          = 1'b0;
            ALUop       = 1'b0;
            Flag        = 1'b0;
            PSW_C       = 1'b0;
            mem_err     = 1'b0;
            halt        = 1'b0;
        end
    end

endmodule
